// File: rtl/frame_buffer_pingpong.sv
// ---------------------------------------------------------------------------
// frame_buffer_pingpong
// Double-buffered frame store between the capture (writer) and display
// (reader) paths. The writer fills one bank while the reader scans the other.
// Banks exchange only on a reader start-of-frame after the writer has
// completed a frame, so the display never shows a torn frame.
//
// Optional build macro: FB_DROP_COUNT_EN adds a saturating 16-bit drop_count
// output, counting frame_drop pulses. It is cleared by rst.
//
// Ports:
//   clk, rst            system clock, async active-high reset
//   wr_sof/wr_eof       writer frame delimiters
//   wr_en/addr/data     pixel write port (into bank wr_bank)
//   rd_sof              reader frame boundary; the only point a swap happens
//   rd_en/addr          pixel read request
//   rd_data/rd_valid    registered read result, 1-cycle latency
//   wr_bank             bank currently owned by the writer
//   frame_pending       completed frame waiting for a swap
//   frame_drop          1-cycle pulse when an incoming frame is discarded
//   drop_count          (FB_DROP_COUNT_EN only) saturating drop counter
// ---------------------------------------------------------------------------
module frame_buffer_pingpong #(
  parameter int            AW       = 15,
  parameter int            DW       = 8,
  parameter int            DEPTH    = 19200,
  parameter logic [DW-1:0] BG_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_sof,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_eof,
  input  logic          rd_sof,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          wr_bank,
  output logic          frame_pending,
  output logic          frame_drop
`ifdef FB_DROP_COUNT_EN
  ,
  output logic [15:0]   drop_count
`endif
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic {
    WR_CLOSED = 1'b0,
    WR_OPEN   = 1'b1
  } wr_state_t;

  wr_state_t     r_wr_state;
  wr_state_t     w_wr_state_nxt;
  logic          r_wr_bank;
  logic          r_frame_pending;
  logic          r_frame_drop;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;

  logic          w_eof_acc;
  logic          w_swap;
  logic          w_pending_nxt;
  logic          w_drop_nxt;
  logic          w_rd_bank;
  logic          w_wr_fire;
  logic          w_rd_in_range;
  logic [AW:0]   w_wr_idx;
  logic [AW:0]   w_rd_idx;

  // Two banks stacked linearly: bank 1 starts at DEPTH.
  logic [DW-1:0] r_mem [0:2*DEPTH-1];

  // Reader always owns the bank the writer does not.
  assign w_rd_bank     = ~r_wr_bank;
  assign w_wr_fire     = wr_en && (r_wr_state == WR_OPEN) && ({1'b0, wr_addr} < LP_DEPTH);
  assign w_rd_in_range = ({1'b0, rd_addr} < LP_DEPTH);
  assign w_wr_idx      = {1'b0, wr_addr} + (r_wr_bank ? LP_DEPTH : '0);
  assign w_rd_idx      = {1'b0, rd_addr} + (w_rd_bank ? LP_DEPTH : '0);

  // Same-cycle ordering: eof completes the frame, then a swap may consume
  // it, then sof sees whether a bank is free.
  always_comb begin
    w_eof_acc      = wr_eof && (r_wr_state == WR_OPEN);
    w_swap         = rd_sof && (r_frame_pending || w_eof_acc);
    w_pending_nxt  = (r_frame_pending || w_eof_acc) && !w_swap;
    w_wr_state_nxt = r_wr_state;
    w_drop_nxt     = 1'b0;
    if (w_eof_acc) begin
      w_wr_state_nxt = WR_CLOSED;
    end
    if (wr_sof) begin
      if (w_pending_nxt) begin
        w_wr_state_nxt = WR_CLOSED;
        w_drop_nxt     = 1'b1;
      end else begin
        w_wr_state_nxt = WR_OPEN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= WR_CLOSED;
    end else begin
      r_wr_state <= w_wr_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank       <= 1'b0;
      r_frame_pending <= 1'b0;
      r_frame_drop    <= 1'b0;
    end else begin
      if (w_swap) begin
        r_wr_bank <= ~r_wr_bank;
      end
      r_frame_pending <= w_pending_nxt;
      r_frame_drop    <= w_drop_nxt;
    end
  end

  // Storage is not reset; writes use the pre-swap bank.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[w_wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_in_range ? r_mem[w_rd_idx] : BG_VALUE;
      end
    end
  end

`ifdef FB_DROP_COUNT_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_count <= '0;
    end else if (w_drop_nxt && (r_drop_count != '1)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign drop_count = r_drop_count;
`endif

  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign wr_bank       = r_wr_bank;
  assign frame_pending = r_frame_pending;
  assign frame_drop    = r_frame_drop;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
module tb_frame_buffer_pingpong;
  localparam int          AW    = 15;
  localparam int          DW    = 8;
  localparam int          DEPTH = 19200;
  localparam logic [7:0]  BG    = 8'h00;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_sof = 1'b0, wr_en = 1'b0, wr_eof = 1'b0;
  logic          rd_sof = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, wr_bank, frame_pending, frame_drop;
`ifdef FB_DROP_COUNT_EN
  logic [15:0]   drop_count;
`endif

  frame_buffer_pingpong #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .BG_VALUE(BG)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_sof(wr_sof), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_eof(wr_eof), .rd_sof(rd_sof), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_bank(wr_bank),
    .frame_pending(frame_pending), .frame_drop(frame_drop)
`ifdef FB_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic bank;
    logic pend;
    logic open;
    logic drop;
  } ctl_t;

  // Events applied in their stated order: frame end, swap, frame start.
  function automatic ctl_t ctl_step(input ctl_t s, input logic sof, input logic eof, input logic rsof);
    ctl_t n;
    n      = s;
    n.drop = 1'b0;
    if (eof && n.open) begin
      n.pend = 1'b1;
      n.open = 1'b0;
    end
    if (rsof && n.pend) begin
      n.bank = ~n.bank;
      n.pend = 1'b0;
    end
    if (sof) begin
      if (!n.pend) n.open = 1'b1;
      else begin
        n.open = 1'b0;
        n.drop = 1'b1;
      end
    end
    return n;
  endfunction

  ctl_t        m_ctl = '0;
  logic [7:0]  m_mem   [0:1][0:DEPTH-1];
  bit          m_known [0:1][0:DEPTH-1];
  logic [7:0]  m_rd = '0;
  bit          m_rd_known = 1'b0;
  logic        m_valid = 1'b0;
  logic [15:0] m_dc = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ctl      <= '0;
      m_rd       <= '0;
      m_rd_known <= 1'b1;
      m_valid    <= 1'b0;
      m_dc       <= '0;
    end else begin
      m_valid <= rd_en;
      if (rd_en) begin
        if (int'(rd_addr) >= DEPTH) begin
          m_rd       <= BG;
          m_rd_known <= 1'b1;
        end else begin
          m_rd       <= m_mem[~m_ctl.bank][rd_addr];
          m_rd_known <= m_known[~m_ctl.bank][rd_addr];
        end
      end
      if (wr_en && m_ctl.open && int'(wr_addr) < DEPTH) begin
        m_mem[m_ctl.bank][wr_addr]   <= wr_data;
        m_known[m_ctl.bank][wr_addr] <= 1'b1;
      end
      m_ctl <= ctl_step(m_ctl, wr_sof, wr_eof, rd_sof);
      if (ctl_step(m_ctl, wr_sof, wr_eof, rd_sof).drop && m_dc != 16'hFFFF)
        m_dc <= m_dc + 16'd1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("m_wr_bank", wr_bank, m_ctl.bank);
      chk("m_pending", frame_pending, m_ctl.pend);
      chk("m_drop", frame_drop, m_ctl.drop);
      chk("m_rd_valid", rd_valid, m_valid);
      if (m_rd_known) chk("m_rd_data", rd_data, m_rd);
`ifdef FB_DROP_COUNT_EN
      chk("m_drop_count", drop_count, m_dc);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
    wr_sof = 1'b0; wr_en = 1'b0; wr_eof = 1'b0; rd_sof = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
  endtask

  task automatic rd_lit(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
    rd_en = 1'b1; rd_addr = a;
    cyc();
    chk(name, rd_data, exp);
    chk({name, "_valid"}, rd_valid, 1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_pending", frame_pending, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_drop", frame_drop, 0);
`ifdef FB_DROP_COUNT_EN
    chk("rst_drop_count", drop_count, 0);
`endif
    rst = 1'b0;
  endtask

  initial begin
    #1;
    @(negedge clk);
    reset_pulse();
    cmp_en = 1'b1;

    // T1: basic frame, swap, readback
    wr_sof = 1'b1; cyc();
    for (int i = 0; i < 4; i++) wr(AW'(i), 8'(8'h11 * (i + 1)));
    wr_eof = 1'b1; cyc();
    chk("t1_pending_set", frame_pending, 1);
    rd_sof = 1'b1; cyc();
    chk("t1_pending_clr", frame_pending, 0);
    chk("t1_wr_bank", wr_bank, 1);
    for (int i = 0; i < 4; i++) rd_lit("t1_rd", AW'(i), 8'(8'h11 * (i + 1)));
    cyc();
    chk("t1_valid_low", rd_valid, 0);

    // T2: completed frame then wr_sof without swap -> drop
    wr_sof = 1'b1; cyc();
    wr(5, 8'hAA);
    wr_eof = 1'b1; cyc();
    wr_sof = 1'b1; cyc();
    chk("t2_drop_pulse", frame_drop, 1);
    cyc();
    chk("t2_drop_end", frame_drop, 0);
    wr(5, 8'h55);
    rd_sof = 1'b1; cyc();
    rd_lit("t2_rd5", 5, 8'hAA);

    // T3: eof and rd_sof in the same cycle
    wr_sof = 1'b1; cyc();
    wr(7, 8'h77);
    wr_eof = 1'b1; rd_sof = 1'b1; cyc();
    chk("t3_pending", frame_pending, 0);
    chk("t3_wr_bank", wr_bank, 1);
    rd_lit("t3_rd7", 7, 8'h77);

    // T4: rd_sof + wr_sof while pending -> swap, no drop
    wr_sof = 1'b1; cyc();
    wr(9, 8'h99);
    wr_eof = 1'b1; cyc();
    rd_sof = 1'b1; wr_sof = 1'b1; cyc();
    chk("t4_no_drop", frame_drop, 0);
    chk("t4_wr_bank", wr_bank, 0);
    rd_lit("t4_rd9_a", 9, 8'h99);
    wr(9, 8'h5A);
    wr_eof = 1'b1; cyc();
    rd_sof = 1'b1; cyc();
    rd_lit("t4_rd9_b", 9, 8'h5A);

    // T5: out-of-range write and read
    wr_sof = 1'b1; cyc();
    wr(0, 8'h01);
    wr_eof = 1'b1; cyc();
    rd_sof = 1'b1; cyc();
    wr_sof = 1'b1; cyc();
    wr(AW'(DEPTH), 8'hEE);
    rd_lit("t5_rd0", 0, 8'h01);
    rd_lit("t5_rd_oor", AW'(DEPTH + 5), BG);

    // T6: reset mid-frame
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        rd_en = 1'b1; rd_addr = 0;
      end
      wr(AW'(100 + i), 8'(8'hC0 + i));
    end
    reset_pulse();
    wr(100, 8'hFF);
    wr_eof = 1'b1; rd_sof = 1'b1; cyc();
    chk("t6_no_swap", wr_bank, 0);
    chk("t6_pending", frame_pending, 0);
    rd_lit("t6_rd_bank1", 0, 8'h01);
    wr_sof = 1'b1; cyc();
    wr_eof = 1'b1; cyc();
    rd_sof = 1'b1; cyc();
    rd_lit("t6_rd100", 100, 8'hC0);
    rd_lit("t6_rd109", 109, 8'hC9);

    // Drops after a fresh reset
    reset_pulse();
    wr_sof = 1'b1; cyc();
    wr_eof = 1'b1; cyc();
    for (int i = 0; i < 3; i++) begin
      wr_sof = 1'b1; cyc();
      chk("t6_drop", frame_drop, 1);
    end
    cyc();
`ifdef FB_DROP_COUNT_EN
    chk("t6_drop_count3", drop_count, 3);
    reset_pulse();
    chk("t6_drop_count_clr", drop_count, 0);
`endif
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_buffer_pingpong.md
Name: frame_buffer_pingpong

Overview:
Double-buffered (ping-pong) frame store between the camera capture path and the VGA read path. The writer fills one bank while the reader scans the other. Banks swap only at a reader frame boundary and only after the writer has completed a full frame, so the display never shows a torn frame. Single clock domain: the capture and display sides are synchronised upstream.

Parameters:
AW, 15, address width per bank (bits)
DW, 8, pixel data width (bits)
DEPTH, 19200, valid words per bank (160x120); must be <= 2**AW
BG_VALUE, 0, value returned for reads at addresses >= DEPTH

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous reset, active-high
wr_sof  in  1  writer start-of-frame pulse
wr_en  in  1  write strobe
wr_addr  in  AW  write pixel address
wr_data  in  DW  write pixel data
wr_eof  in  1  writer end-of-frame pulse; frame complete
rd_sof  in  1  reader start-of-frame pulse; swap request point
rd_en  in  1  read strobe
rd_addr  in  AW  read pixel address
rd_data  out  DW  registered read data
rd_valid  out  1  rd_data valid; rd_en delayed by one cycle
wr_bank  out  1  bank currently owned by the writer
frame_pending  out  1  completed frame waiting for swap
frame_drop  out  1  one-cycle pulse: incoming frame discarded

Behaviour:
- Storage: 2*DEPTH words, indexed as {bank, addr}. Contents are not reset.
- Reset values: wr_bank=0, rd_bank=1 (internal), frame_pending=0, wr_open=0 (internal), rd_data=0, rd_valid=0, frame_drop=0.
- Write side:
  - A write occurs when wr_en & wr_open & (wr_addr < DEPTH), into bank wr_bank.
  - Out-of-range and not-open writes are silently ignored.
- wr_sof:
  - If frame_pending=0 after this cycle's swap evaluation: wr_open<=1.
  - Otherwise: wr_open<=0 and frame_drop pulses for 1 cycle. All writes are ignored until the next accepted wr_sof.
- wr_eof with wr_open=1: frame_pending<=1, wr_open<=0. A wr_eof with wr_open=0 is ignored.
- Swap: on rd_sof, when (frame_pending | accepted wr_eof in the same cycle):
  - wr_bank and rd_bank are exchanged and frame_pending<=0.
  - Otherwise the reader repeats the current bank; no change.
- Priority within one cycle: wr_eof, then swap, then wr_sof.
  - wr_eof+rd_sof: the frame completes and swaps the same cycle.
  - rd_sof+wr_sof while pending: the swap frees a bank, so wr_sof is accepted. No drop.
  - A write in the same cycle as a swap goes to the pre-swap wr_bank.
- Read side:
  - rd_data<=mem[{rd_bank,rd_addr}] on rd_en, using rd_bank before any same-cycle swap.
  - Latency is 1 cycle. rd_valid<=rd_en.
  - rd_data holds its value when rd_en=0.
  - rd_addr >= DEPTH returns BG_VALUE.
- Writer and reader never address the same bank, so there is no read/write collision.
- Reset mid-frame: the open frame is abandoned. After reset the writer needs a new wr_sof. The reader sees the previous contents of bank 1.

Optional Feature:
FB_DROP_COUNT_EN:
- Defined: adds output drop_count[15:0]. It increments on each frame_drop pulse, saturates at 16'hFFFF and is cleared by rst.
- Undefined: the port and counter are absent; frame_drop is unchanged.

Test Plan:
1. Reset, wr_sof, write addr 0..3 = 8'h11..8'h44, wr_eof, rd_sof, read addr 0..3 -> rd_data 11,22,33,44 each one cycle after rd_en; rd_valid aligned; frame_pending 1 then 0; wr_bank 0->1.
2. Complete frame A (addr5=8'hAA), no rd_sof, then wr_sof -> frame_drop pulses once. Following writes are ignored. Later rd_sof then read addr5 -> 8'hAA.
3. Assert wr_eof and rd_sof in the same cycle, then read in the following cycle -> new frame visible, frame_pending stays 0.
4. Pending frame; rd_sof and wr_sof in the same cycle -> swap occurs, no frame_drop, next writes land in the freed bank (verify after a second swap).
5. Write wr_addr=19200, and separately read rd_addr=19205 -> write ignored, rd_data=BG_VALUE (8'h00).
6. Assert rst mid-frame after 10 writes -> outputs at reset values. Writes without a new wr_sof are ignored. With FB_DROP_COUNT_EN, three drops give drop_count=3, and rst clears it to 0.
